// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response plus the consumer-side
// head, stall and redirect signals. master = fetch_queue, slave = environment.
interface fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_valid;
  logic [WIDTH-1:0] imem_rdata;
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             instr_valid;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out,
    input  imem_valid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
    output imem_valid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, in-order prefetch queue,
// stall hold and redirect flush. Optional same-cycle bypass: FETCH_BYPASS_EN.
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  // Handshakes: a request is taken every cycle imem_req=1 and its word comes
  // back on imem_valid in order; the head transfers at an edge where
  // instr_valid && !stall, and is otherwise held unchanged.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;

  logic [WIDTH-1:0] q_instr [DEPTH];
  logic [WIDTH-1:0] q_pc    [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  cnt_t             count;
  cnt_t             outstanding;
  cnt_t             discard;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] resp_pc;
  logic [WIDTH-1:0] hold_instr;
  logic [WIDTH-1:0] hold_pc;

  logic             resp;
  logic             keep;
  logic             q_empty;
  logic             byp;
  logic             head_valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CW:0]      inflight;
  logic [WIDTH-1:0] redirect_aligned;

  assign q_empty          = (count == '0);
  assign inflight         = {1'b0, count} + {1'b0, outstanding};
  assign redirect_aligned = bus.redirect_pc & ~WIDTH'(3);

  // Responses with nothing outstanding are stray and ignored entirely.
  assign resp = bus.imem_valid && (outstanding != '0);
  assign keep = resp && (discard == '0) && !bus.redirect;

`ifdef FETCH_BYPASS_EN
  assign byp = keep && q_empty;
`else
  assign byp = 1'b0;
`endif

  assign head_valid = !bus.redirect && (!q_empty || byp);
  assign pop        = head_valid && !bus.stall && !byp;
  // A bypassed word consumed in the same cycle never occupies a slot.
  assign push       = keep && !(byp && !bus.stall);
  assign issue      = !rst && !bus.redirect && (discard == '0) &&
                      (inflight < (CW+1)'(DEPTH));

  always_comb begin
    bus.imem_req    = issue;
    bus.imem_addr   = fetch_pc;
    bus.instr_valid = head_valid;
    if (byp) begin
      bus.instr_out = bus.imem_rdata;
      bus.pc_out    = resp_pc;
    end else if (!q_empty) begin
      bus.instr_out = q_instr[rd_ptr];
      bus.pc_out    = q_pc[rd_ptr];
    end else begin
      bus.instr_out = hold_instr;
      bus.pc_out    = hold_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      hold_instr  <= '0;
      hold_pc     <= '0;
    end else if (bus.redirect) begin
      // Everything in flight, minus a word landing this cycle, is stale.
      fetch_pc    <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - cnt_t'(resp);
      discard     <= outstanding - cnt_t'(resp);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + WIDTH'(4);
      end
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(resp);
      if (resp && (discard != '0)) begin
        discard <= discard - cnt_t'(1);
      end
      if (keep) begin
        resp_pc <= resp_pc + WIDTH'(4);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + cnt_t'(push) - cnt_t'(pop);
      if (head_valid) begin
        hold_instr <= bus.instr_out;
        hold_pc    <= bus.pc_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (inflight <= (CW+1)'(DEPTH));
      assert (discard <= outstanding);
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Generates sequential PCs and issues requests to instruction memory.
- Buffers returned instructions with their PCs in a small in-order prefetch queue.
- Presents the queue head to the IF/ID register. The hazard unit's stall holds the head, and a branch/jump redirect flushes all fetch state.

Parameters:
- WIDTH, 32, data and address width.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, prefetch queue entries. Must be a power of 2, ≥2. Also the cap on queued + outstanding requests.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  request strobe, one word per cycle when high.
- imem_addr  output  WIDTH  word-aligned fetch address, valid when imem_req=1.
- imem_valid  input  1  response strobe. Responses return in order, latency ≥1 cycle.
- imem_rdata  input  WIDTH  instruction word, valid when imem_valid=1.
- stall  input  1  consumer not accepting; head is held.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  WIDTH  new fetch address, low 2 bits ignored (forced 0).
- instr_valid  output  1  queue head valid.
- instr_out  output  WIDTH  head instruction.
- pc_out  output  WIDTH  PC of head instruction.

Behaviour:
- Reset (rst=1 at clock edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0.
  - instr_valid=0, instr_out=0, pc_out=0, imem_req=0 in the cycle after reset.
- Issue:
  - imem_req=1 when !rst, !redirect, discard==0, and count+outstanding < DEPTH.
  - imem_addr=fetch_pc. On issue: fetch_pc += 4 (wraps modulo 2^WIDTH) and outstanding += 1.
- Response:
  - imem_valid with discard>0: word dropped, discard -= 1, outstanding -= 1.
  - Otherwise: word pushed with its PC (tracked by a separate resp_pc register advancing by 4), outstanding -= 1.
  - imem_valid with outstanding==0: ignored, no state change.
- Pop: when instr_valid && !stall, the head is removed at the edge. A simultaneous push and pop is legal and keeps count unchanged.
- Full: count+outstanding ≤ DEPTH always, so a push never overflows. No request is issued when the cap is reached.
- Empty: instr_valid=0. instr_out and pc_out hold their last values (don't-care for the consumer).
- Redirect (highest priority after rst):
  - Queue cleared; fetch_pc and resp_pc ← {redirect_pc[WIDTH-1:2],2'b00}.
  - discard ← outstanding − (imem_valid ? 1 : 0); any response arriving in the redirect cycle is dropped.
  - No request and no pop in the redirect cycle; instr_valid=0 the next cycle.
  - First request to redirect_pc is issued the first cycle discard==0, which is the next cycle if nothing is in flight.
- Redirect during stall: the flush still occurs; stall has no effect on the flush.
- Reset mid-operation: in-flight responses after reset are ignored because outstanding=0. Memory must not return them; the bench must quiesce memory with rst.
- Latency, without bypass: response at cycle N → instr_valid=1 at N+1.

Optional Feature:
- Macro: FETCH_BYPASS_EN
- Defined:
  - When the queue is empty, discard==0, and imem_valid=1, the response appears combinationally on instr_out/pc_out with instr_valid=1 in the same cycle.
  - If !stall it is consumed without being enqueued. If stall, it is enqueued normally.
  - Redirect in the same cycle suppresses the bypass (instr_valid=0).
- Not defined: all responses go through the queue, with 1-cycle minimum latency.

Test Plan:
- Reset, then a memory with latency 1 and stall=0 → imem_addr sequence 0x0,0x4,0x8,…. pc_out/instr_out match each address/word, one instruction per cycle after fill. instr_valid first high 2 cycles after the first request (1 cycle with FETCH_BYPASS_EN).
- stall=1 held for 10 cycles, DEPTH=4 → at most 4 requests outstanding+queued, then imem_req=0. Head stays pc_out=0x8 throughout. Release → 0x8,0xC,0x10,0x14 delivered in order with no duplicates or gaps.
- Latency-3 memory, redirect to 0x100 with 2 requests outstanding → both stale responses dropped. imem_req stays low until they return. Next delivered pc_out=0x100, then 0x104.
- Redirect with redirect_pc=0x203 and imem_valid=1 in the same cycle → response dropped, next imem_addr=0x200, instr_valid=0 the following cycle.
- fetch_pc=0xFFFF_FFFC, WIDTH=32 → next request address 0x0000_0000, PCs wrap correctly in the queue.
- rst asserted mid-stream with 3 entries queued → the cycle after, instr_valid=0 and imem_req=0. Next request is to RESET_PC.
